// File: rtl/crc_serial_gen_if.sv
// Serial CRC generator bus: message bits and INIT in, serial/parallel CRC out.
// The master is the upstream serialiser and the slave is the generator.
interface crc_serial_gen_if #(parameter int CRC_W = 8) ();
  logic             ACTIVE;
  logic             DATA;
  logic             INIT;
  logic             CRC;
  logic             Valid;
  logic             DONE;
  logic [CRC_W-1:0] CRC_PAR;

  modport master (output ACTIVE, DATA, INIT, input  CRC, Valid, DONE, CRC_PAR);
  modport slave  (input  ACTIVE, DATA, INIT, output CRC, Valid, DONE, CRC_PAR);
endinterface

// File: rtl/crc_serial_gen.sv
// Bit-serial CRC generator: absorbs a message while ACTIVE is high, then shifts
// the CRC out LSB-first with Valid, a parallel snapshot and a DONE pulse.
module crc_serial_gen #(
  parameter int               CRC_W = 8,
  parameter logic [CRC_W-1:0] TAPS  = 8'h44,
  parameter logic [CRC_W-1:0] SEED  = 8'hD8
) (
  input logic             CLK,
  input logic             RST,
  crc_serial_gen_if.slave bus
);
  localparam int CNT_W = $clog2(CRC_W + 1);
  // The MSB always takes the feedback, whatever TAPS says about that bit.
  localparam logic [CRC_W-1:0] MASK = TAPS | {1'b1, {(CRC_W-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CRC_W);

  typedef enum logic [1:0] {IDLE, ABSORB, EMIT} state_t;

  state_t           state;
  logic [CRC_W-1:0] lfsr, lfsr_next, crc_par;
  logic [CNT_W-1:0] cnt;
  logic             crc, valid, done, fb;

  assign fb        = lfsr[0] ^ bus.DATA;
  assign lfsr_next = (lfsr >> 1) ^ ({CRC_W{fb}} & MASK);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      lfsr    <= SEED;
      state   <= IDLE;
      cnt     <= '0;
      crc     <= 1'b0;
      valid   <= 1'b0;
      done    <= 1'b0;
      crc_par <= '0;
    end else if (bus.INIT) begin
      lfsr  <= SEED;
      state <= IDLE;
      cnt   <= '0;
      crc   <= 1'b0;
      valid <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          crc   <= 1'b0;
          valid <= 1'b0;
          done  <= 1'b0;
          if (bus.ACTIVE) begin
            lfsr  <= lfsr_next;
            state <= ABSORB;
          end
        end
        ABSORB: begin
          if (bus.ACTIVE) begin
            lfsr <= lfsr_next;
          end else begin
            // End of message: snapshot and emit bit 0 on the same edge.
            crc_par <= lfsr;
            crc     <= lfsr[0];
            valid   <= 1'b1;
            done    <= (CRC_W == 1);
            lfsr    <= lfsr >> 1;
            cnt     <= CNT_W'(1);
            state   <= EMIT;
          end
        end
        EMIT: begin
          if (cnt < LAST) begin
            crc   <= lfsr[0];
            valid <= 1'b1;
            done  <= (cnt == LAST - CNT_W'(1));
            lfsr  <= lfsr >> 1;
            cnt   <= cnt + CNT_W'(1);
          end else begin
            crc   <= 1'b0;
            valid <= 1'b0;
            done  <= 1'b0;
            lfsr  <= SEED;
            cnt   <= '0;
            state <= IDLE;
          end
        end
        default: begin
          lfsr  <= SEED;
          state <= IDLE;
          cnt   <= '0;
          crc   <= 1'b0;
          valid <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.CRC     = crc;
  assign bus.Valid   = valid;
  assign bus.DONE    = done;
  assign bus.CRC_PAR = crc_par;
endmodule

// File: tb/tb_crc_serial_gen.sv
// Directed and random frames on an 8-bit default generator and a 16-bit
// CCITT-style instance, checked against a bit-at-a-time division model.
module tb_crc_serial_gen;
  logic CLK = 1'b0;
  logic RST = 1'b0;
  int   total = 0;
  int   bad   = 0;

  crc_serial_gen_if #(.CRC_W(8))  i8 ();
  crc_serial_gen_if #(.CRC_W(16)) i16 ();

  crc_serial_gen dut8 (.CLK(CLK), .RST(RST), .bus(i8.slave));
  crc_serial_gen #(.CRC_W(16), .TAPS(16'h1021), .SEED(16'hFFFF))
    dut16 (.CLK(CLK), .RST(RST), .bus(i16.slave));

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int w, input logic act, input logic dat, input logic ini);
    if (w == 8) begin
      i8.ACTIVE = act; i8.DATA = dat; i8.INIT = ini;
    end else begin
      i16.ACTIVE = act; i16.DATA = dat; i16.INIT = ini;
    end
  endtask

  task automatic sample(input int w, output logic c, output logic v, output logic d,
                        output logic [31:0] p);
    if (w == 8) begin
      c = i8.CRC; v = i8.Valid; d = i8.DONE; p = 32'(i8.CRC_PAR);
    end else begin
      c = i16.CRC; v = i16.Valid; d = i16.DONE; p = 32'(i16.CRC_PAR);
    end
  endtask

  // Reference: shift the message through the register one bit at a time,
  // adding the polynomial whenever the bit falling out disagrees with the data.
  function automatic logic [31:0] crc_ref(input int w, input logic [31:0] taps,
                                          input logic [31:0] seed, input bit msg[$]);
    logic [31:0] poly;
    logic [31:0] r;
    poly = (taps | (32'd1 << (w - 1))) & ((32'd1 << w) - 32'd1);
    r    = seed;
    foreach (msg[i]) begin
      if (r[0] != msg[i]) r = (r >> 1) ^ poly;
      else                r = r >> 1;
    end
    return r;
  endfunction

  task automatic run_frame(input int w, input bit msg[$], input bit toggle,
                           input logic [31:0] exp, input string name);
    logic c, v, d;
    logic [31:0] p;
    foreach (msg[i]) begin
      drive(w, 1'b1, msg[i], 1'b0);
      tick();
    end
    drive(w, 1'b0, 1'($urandom), 1'b0);
    tick();
    sample(w, c, v, d, p);
    chk($sformatf("%s par", name), p, exp);
    for (int i = 0; i < w; i++) begin
      sample(w, c, v, d, p);
      chk($sformatf("%s valid[%0d]", name, i), 32'(v), 32'd1);
      chk($sformatf("%s crc[%0d]", name, i), 32'(c), 32'(exp[i]));
      chk($sformatf("%s done[%0d]", name, i), 32'(d), 32'(i == w - 1));
      if (toggle) drive(w, 1'($urandom), 1'($urandom), 1'b0);
      tick();
    end
    drive(w, 1'b0, 1'b0, 1'b0);
    sample(w, c, v, d, p);
    chk($sformatf("%s valid_end", name), 32'(v), 32'd0);
    chk($sformatf("%s crc_end", name), 32'(c), 32'd0);
    chk($sformatf("%s done_end", name), 32'(d), 32'd0);
  endtask

  initial begin
    logic c, v, d;
    logic [31:0] p;
    bit msg[$];
    int n;

    drive(8, 1'b0, 1'b0, 1'b0);
    drive(16, 1'b0, 1'b0, 1'b0);
    #2;
    sample(8, c, v, d, p);
    chk("rst valid", 32'(v), 32'd0);
    chk("rst par", p, 32'd0);
    #20 RST = 1'b1;

    // Idle with ACTIVE low: nothing comes out.
    for (int i = 0; i < 20; i++) begin
      tick();
      sample(8, c, v, d, p);
      chk($sformatf("idle outs[%0d]", i), {p[28:0], c, v, d}, 32'd0);
    end

    msg = {1'b1};
    run_frame(8, msg, 1'b0, 32'hA8, "one_bit_1");
    msg = {1'b1, 1'b1};
    run_frame(8, msg, 1'b0, 32'h90, "two_bits_a");
    run_frame(8, msg, 1'b0, 32'h90, "two_bits_b");
    msg = {1'b0};
    run_frame(8, msg, 1'b0, 32'h6C, "one_bit_0");

    // INIT during the 4th Valid cycle aborts the emission without DONE.
    drive(8, 1'b1, 1'b1, 1'b0);
    tick();
    drive(8, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    tick();
    tick();
    sample(8, c, v, d, p);
    chk("init pre valid", 32'(v), 32'd1);
    drive(8, 1'b0, 1'b0, 1'b1);
    tick();
    drive(8, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      sample(8, c, v, d, p);
      chk($sformatf("init quiet[%0d]", i), {c, v, d}, 32'd0);
      chk($sformatf("init par[%0d]", i), p, 32'hA8);
      tick();
    end
    msg = {1'b1};
    run_frame(8, msg, 1'b0, 32'hA8, "after_init");

    msg = {1'b1, 1'b0, 1'b1};
    run_frame(8, msg, 1'b1, crc_ref(8, 32'h44, 32'hD8, msg), "toggle_emit");

    for (int f = 0; f < 6; f++) begin
      msg.delete();
      n = int'($urandom_range(1, 24));
      for (int i = 0; i < n; i++) msg.push_back(1'($urandom));
      run_frame(8, msg, f[0], crc_ref(8, 32'h44, 32'hD8, msg), $sformatf("rnd8_%0d", f));
    end

    for (int f = 0; f < 6; f++) begin
      msg.delete();
      n = int'($urandom_range(1, 40));
      for (int i = 0; i < n; i++) msg.push_back(1'($urandom));
      run_frame(16, msg, f[0], crc_ref(16, 32'h1021, 32'hFFFF, msg), $sformatf("rnd16_%0d", f));
    end

    // Asynchronous reset in the middle of an emission.
    drive(8, 1'b1, 1'b0, 1'b0);
    tick();
    drive(8, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    #2 RST = 1'b0;
    #1;
    sample(8, c, v, d, p);
    chk("async rst outs", {c, v, d}, 32'd0);
    chk("async rst par", p, 32'd0);
    #10 RST = 1'b1;
    tick();
    msg = {1'b1};
    run_frame(8, msg, 1'b0, 32'hA8, "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
